ad1939_adc_rx: RTL
==================

Name: ad1939_adc_rx

Overview:
Receive-side counterpart of the AD1939 DAC serializer. Oversamples the codec ADC serial port (abclk, alrclk, asdata1, asdata2) in the system clock domain and deserializes I2S or left-justified slots. Emits one Avalon-ST word per channel (L1, R1, L2, R2) with channel tag and ready/valid backpressure. Sits between the ad1939 physical pins and the audio streaming fabric.

Parameters:
DATA_WIDTH, 24, bits captured per slot, MSB first; valid range 16..32.
MSB_DELAY, 1, BCLK rising edges between an LRCLK transition and the MSB: 1 = I2S, 0 = left-justified.

Ports:
clk  in  1  system clock, at least 4x abclk frequency
reset_n  in  1  asynchronous active-low reset
enable  in  1  capture enable
abclk  in  1  codec bit clock, sampled as data
alrclk  in  1  codec LR clock; low = left
asdata1  in  1  ADC serial data, pair 1
asdata2  in  1  ADC serial data, pair 2
out_data  out  DATA_WIDTH  sample word
out_channel  out  2  0=L1, 1=R1, 2=L2, 3=R2
out_valid  out  1  word valid
out_ready  in  1  sink ready
err_clr  in  1  one-cycle pulse; clears sticky flags
overflow  out  1  sticky: a completed pair was dropped
short_frame  out  1  sticky: a slot ended before DATA_WIDTH bits

Behaviour:
- Reset: all outputs 0, all internal state cleared, capture state = WAIT_LR.
- Synchronization: abclk, alrclk, asdata1, asdata2 each pass an identical 2-FF synchronizer plus one history FF, so all four stay aligned.
- BCLK edge: a rising edge is when synced abclk = 1 and its history = 0. All actions below occur only on the clk cycle of a BCLK rising edge.
- lr_prev holds alrclk as sampled at the previous BCLK edge.
- States:
  - IDLE (enable = 0): no capture; the output stage keeps draining. Entered from any state within 1 clk of enable falling.
  - WAIT_LR: entered when enable rises. Waits for lr != lr_prev, then goes to SHIFT with bit_cnt = 0 and skip = MSB_DELAY. Partial slots are never emitted.
  - SHIFT, on each edge:
    - If lr != lr_prev: start a new slot (bit_cnt = 0, skip = MSB_DELAY). If the old slot had bit_cnt < DATA_WIDTH, set short_frame and discard the partial words.
    - Else if skip != 0: decrement skip.
    - Else if bit_cnt < DATA_WIDTH: shift asdata1 and asdata2 into two shift registers, then increment bit_cnt.
    - Else: ignore the bit (slot padding).
  - The edge on which bit_cnt reaches DATA_WIDTH completes the pair and latches {sr1, ch = 0|lr} and {sr2, ch = 2|lr} into the pair buffer, with pending = 2.
- Pair buffer (2 words) feeds a single output register:
  - The register loads the next pending word when empty, or on the same cycle its word is accepted (out_valid & out_ready). Order is always the line-1 word, then the line-2 word.
  - Latency from the completing BCLK edge to out_valid on the first word: 1 clk.
  - out_data and out_channel are held stable while out_valid = 1 and out_ready = 0.
  - Throughput: 1 word/clk when ready.
- Overflow: a pair completes while pending != 0 → the new pair is dropped whole and overflow is set. Buffered data is untouched.
- err_clr: clears overflow and short_frame. If it coincides with a new error event, the flag stays set (set wins).
- Reset mid-slot: everything is discarded and the block restarts in WAIT_LR (or IDLE if enable = 0).

Optional Feature:
AD1939_ADC_RX_STATS_EN
- Defined: adds output frame_count[31:0], which increments on each completed right-slot pair (wraps at 2^32), and output drop_count[15:0], which increments per dropped pair and saturates at 0xFFFF. Both reset to 0. Both are cleared by err_clr; an increment coinciding with err_clr makes the counter 1.
- Undefined: neither port nor its logic exists.

Test Plan:
1. Default parameters, abclk = clk/8, 64-BCLK I2S frame, out_ready = 1. L1 = 0x800001, R1 = 0x7FFFFE, L2 = 0x123456, R2 = 0xABCDEF → words in order (ch0, 0x800001), (ch2, 0x123456), (ch1, 0x7FFFFE), (ch3, 0xABCDEF); each valid for exactly 1 clk; no flags set.
2. out_ready = 0 for two slots → first pair held with out_data stable; second pair dropped and overflow = 1. Raise out_ready → only ch0 and ch2 words appear. err_clr → overflow = 0.
3. LR toggles after 16 data bits in the left slot → no left words emitted and short_frame = 1. The following right slot is emitted correctly.
4. enable rises mid-left-slot → nothing is emitted until after the next LR edge. The first word is ch1, R1.
5. MSB_DELAY = 0 with left-justified stimulus of the test-1 values → identical output sequence.
6. Assert reset_n = 0 for 3 clk mid-slot → all outputs 0 during reset. Capture resumes correctly from the next full slot. With STATS enabled, frame_count restarts from 0.

Source files
------------

// File: rtl/ad1939_adc_rx.sv
// ad1939_adc_rx: AD1939 ADC serial port deserializer to Avalon-ST, one word per channel.
// Optional AD1939_ADC_RX_STATS_EN adds frame_count / drop_count outputs.
module ad1939_adc_rx #(
  parameter int DATA_WIDTH = 24,
  parameter int MSB_DELAY  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  abclk,
  input  logic                  alrclk,
  input  logic                  asdata1,
  input  logic                  asdata2,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_channel,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  err_clr,
  output logic                  overflow,
`ifdef AD1939_ADC_RX_STATS_EN
  output logic [31:0]           frame_count,
  output logic [15:0]           drop_count,
`endif
  output logic                  short_frame
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] DW_C = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_C = CW'(DATA_WIDTH - 1);
  localparam int WW = DATA_WIDTH + 2;
  typedef enum logic [1:0] {IDLE, WAIT_LR, SHIFT} state_t;
  state_t state_q, state_d;
  logic [3:0] sync1_q, sync2_q, hist_q;
  logic lr_prev_q, lr_prev_d, skip_q, skip_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] sr1_q, sr1_d, sr2_q, sr2_d;
  logic [WW-1:0] buf1_q, buf1_d, buf2_q, buf2_d, w1, w2;
  logic [1:0] pending_q, pending_d, pend;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0] out_channel_q, out_channel_d;
  logic out_valid_q, out_valid_d, overflow_q, overflow_d, short_q, short_d;
  logic bclk_edge, lr, lr_chg, start, shifting, complete, short_ev, drop, new_pair, load;
`ifdef AD1939_ADC_RX_STATS_EN
  logic [31:0] fc_q, fc_d;
  logic [15:0] dc_q, dc_d;
`endif
  // Slot bits are taken from the history stage, i.e. the value just before the rising edge
  always_comb begin
    bclk_edge = sync2_q[0] & ~hist_q[0];
    lr        = hist_q[1];
    lr_chg    = lr != lr_prev_q;
    start     = bclk_edge && lr_chg && enable && state_q != IDLE;
    shifting  = state_q == SHIFT && bclk_edge && !lr_chg && !skip_q && bit_cnt_q < DW_C;
    complete  = shifting && bit_cnt_q == LAST_C;
    short_ev  = state_q == SHIFT && bclk_edge && lr_chg && bit_cnt_q < DW_C;
    drop      = complete && pending_q != 2'd0;
    new_pair  = complete && pending_q == 2'd0;
    state_d   = !enable ? IDLE : state_q == IDLE ? WAIT_LR : start ? SHIFT : state_q;
    lr_prev_d = bclk_edge ? lr : lr_prev_q;
    bit_cnt_d = start ? '0 : shifting ? bit_cnt_q + 1'b1 : bit_cnt_q;
    skip_d    = start ? (MSB_DELAY != 0) : (state_q == SHIFT && bclk_edge) ? 1'b0 : skip_q;
    sr1_d     = shifting ? {sr1_q[DATA_WIDTH-2:0], hist_q[2]} : sr1_q;
    sr2_d     = shifting ? {sr2_q[DATA_WIDTH-2:0], hist_q[3]} : sr2_q;
    w1        = new_pair ? {1'b0, lr, sr1_d} : buf1_q;
    w2        = new_pair ? {1'b1, lr, sr2_d} : buf2_q;
    buf1_d    = w1;
    buf2_d    = w2;
    pend      = new_pair ? 2'd2 : pending_q;
    load      = pend != 2'd0 && (!out_valid_q || out_ready);
    pending_d = pend - {1'b0, load};
    out_valid_d = load || (out_valid_q && !out_ready);
    {out_channel_d, out_data_d} = load ? (pend == 2'd2 ? w1 : w2) : {out_channel_q, out_data_q};
    overflow_d = drop || (overflow_q && !err_clr);
    short_d    = short_ev || (short_q && !err_clr);
`ifdef AD1939_ADC_RX_STATS_EN
    fc_d = (err_clr ? 32'd0 : fc_q) + {31'd0, complete && lr};
    dc_d = err_clr ? {15'd0, drop} : (drop && dc_q != 16'hFFFF) ? dc_q + 16'd1 : dc_q;
`endif
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      hist_q        <= '0;
      state_q       <= WAIT_LR;
      lr_prev_q     <= 1'b0;
      skip_q        <= 1'b0;
      bit_cnt_q     <= '0;
      sr1_q         <= '0;
      sr2_q         <= '0;
      buf1_q        <= '0;
      buf2_q        <= '0;
      pending_q     <= '0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_valid_q   <= 1'b0;
      overflow_q    <= 1'b0;
      short_q       <= 1'b0;
`ifdef AD1939_ADC_RX_STATS_EN
      fc_q          <= '0;
      dc_q          <= '0;
`endif
    end else begin
      sync1_q       <= {asdata2, asdata1, alrclk, abclk};
      sync2_q       <= sync1_q;
      hist_q        <= sync2_q;
      state_q       <= state_d;
      lr_prev_q     <= lr_prev_d;
      skip_q        <= skip_d;
      bit_cnt_q     <= bit_cnt_d;
      sr1_q         <= sr1_d;
      sr2_q         <= sr2_d;
      buf1_q        <= buf1_d;
      buf2_q        <= buf2_d;
      pending_q     <= pending_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_valid_q   <= out_valid_d;
      overflow_q    <= overflow_d;
      short_q       <= short_d;
`ifdef AD1939_ADC_RX_STATS_EN
      fc_q          <= fc_d;
      dc_q          <= dc_d;
`endif
    end
  end
  assign out_data    = out_data_q;
  assign out_channel = out_channel_q;
  assign out_valid   = out_valid_q;
  assign overflow    = overflow_q;
  assign short_frame = short_q;
`ifdef AD1939_ADC_RX_STATS_EN
  assign frame_count = fc_q;
  assign drop_count  = dc_q;
`endif
endmodule
